// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: streams the data-memory image and then the instruction-memory
// image into the cpu core through its external write ports. After a settle
// delay it raises the core enable and counts run cycles. The run ends when the
// STOP opcode appears on the instruction bus, or when the run timeout expires.
//
// Stream handshake: a word is consumed on a rising clk edge where
// s_valid_i && s_ready_o. s_ready_o is registered and depends only on the
// controller state, never on s_valid_i. The producer may hold or change
// s_valid_i at any time. A word offered while s_ready_o is low stays unconsumed.
module cpu_boot_ctrl #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned IMEM_DEPTH    = 512,
  parameter int unsigned DMEM_DEPTH    = 1024,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [5:0]  STOP_OPCODE   = 6'b111110,
  parameter int unsigned CYC_W         = 32,
  parameter int unsigned MAX_CYCLES    = 2**20
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] addr_ext_o,
  output logic              wen_ext_o,
  output logic              ren_ext_o,
  output logic [DATA_W-1:0] wdata_ext_o,
  output logic [ADDR_W-1:0] addr_ext_2_o,
  output logic              wen_ext_2_o,
  output logic              ren_ext_2_o,
  output logic [DATA_W-1:0] wdata_ext_2_o,
  output logic              enable_o,
  input  logic [DATA_W-1:0] instr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [1:0]        test_id_o,
  output logic [CYC_W-1:0]  cycles_o,
  output logic [2:0]        dbg_state_o
);

  localparam int unsigned MAX_DEPTH = (DMEM_DEPTH > IMEM_DEPTH) ? DMEM_DEPTH : IMEM_DEPTH;
  localparam int unsigned IDX_W     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int unsigned SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_W-1:0] D_LAST   = IDX_W'(DMEM_DEPTH - 1);
  localparam logic [IDX_W-1:0] I_LAST   = IDX_W'(IMEM_DEPTH - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_SAT  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_D  = 3'd1,
    S_LOAD_I  = 3'd2,
    S_SETTLE  = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5,
    S_TIMEOUT = 3'd6
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              r_s_ready;
  logic [ADDR_W-1:0] r_addr_ext;
  logic              r_wen_ext;
  logic [DATA_W-1:0] r_wdata_ext;
  logic [ADDR_W-1:0] r_addr_ext_2;
  logic              r_wen_ext_2;
  logic [DATA_W-1:0] r_wdata_ext_2;
  logic              r_enable;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;
  logic [1:0]        r_test_id;
  logic [CYC_W-1:0]  r_cycles;

  logic [ADDR_W-1:0] w_idx_addr;
  logic              w_stop;
  logic              w_unused_instr;

  // Byte address of the current word; zero-extended or truncated to ADDR_W.
  assign w_idx_addr     = ADDR_W'({r_idx, 2'b00});
  // Only the opcode field and the two test-selector bits of the instruction matter here.
  assign w_stop         = (instr_i[DATA_W-1 -: 6] == STOP_OPCODE);
  assign w_unused_instr = ^instr_i[DATA_W-7:2];

  // Controller FSM: state, word index, write ports, enable, status and cycle count.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_settle_cnt  <= '0;
      r_s_ready     <= 1'b0;
      r_addr_ext    <= '0;
      r_wen_ext     <= 1'b0;
      r_wdata_ext   <= '0;
      r_addr_ext_2  <= '0;
      r_wen_ext_2   <= 1'b0;
      r_wdata_ext_2 <= '0;
      r_enable      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_test_id     <= '0;
      r_cycles      <= '0;
    end else begin
      // Write enables are single-cycle pulses; address and data hold between writes.
      r_wen_ext   <= 1'b0;
      r_wen_ext_2 <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start_i) begin
            r_state      <= S_LOAD_D;
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_cycles     <= '0;
            r_test_id    <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b1;
            r_s_ready    <= 1'b1;
          end
        end
        S_LOAD_D: begin
          if (s_valid_i && r_s_ready) begin
            r_wen_ext_2   <= 1'b1;
            r_addr_ext_2  <= w_idx_addr;
            r_wdata_ext_2 <= s_data_i;
            if (r_idx == D_LAST) begin
              // The imem stream follows directly; ready stays high.
              r_state <= S_LOAD_I;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_LOAD_I: begin
          if (s_valid_i && r_s_ready) begin
            r_wen_ext   <= 1'b1;
            r_addr_ext  <= w_idx_addr;
            r_wdata_ext <= s_data_i;
            if (r_idx == I_LAST) begin
              // The last imem write pulse lands in the first SETTLE cycle.
              r_state      <= S_SETTLE;
              r_idx        <= '0;
              r_settle_cnt <= '0;
              r_s_ready    <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == SET_LAST) begin
            r_state  <= S_RUN;
            r_enable <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (w_stop) begin
            // STOP takes priority over a coincident timeout; count is not bumped.
            r_state   <= S_DONE;
            r_test_id <= instr_i[1:0];
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (r_cycles == CYC_LAST) begin
            r_state   <= S_TIMEOUT;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end else if (r_cycles != CYC_SAT) begin
            r_cycles <= r_cycles + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_s_ready <= 1'b0;
          r_enable  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready_o     = r_s_ready;
  assign addr_ext_o    = r_addr_ext;
  assign wen_ext_o     = r_wen_ext;
  assign ren_ext_o     = 1'b0;
  assign wdata_ext_o   = r_wdata_ext;
  assign addr_ext_2_o  = r_addr_ext_2;
  assign wen_ext_2_o   = r_wen_ext_2;
  assign ren_ext_2_o   = 1'b0;
  assign wdata_ext_2_o = r_wdata_ext_2;
  assign enable_o      = r_enable;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign timeout_o     = r_timeout;
  assign test_id_o     = r_test_id;
  assign cycles_o      = r_cycles;
  assign dbg_state_o   = r_state;

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
Synthesisable boot/run controller for the `cpu` core. It streams initial data-memory and instruction-memory images into the core through its two external write ports, then releases `enable`. It counts executed cycles, detects the STOP opcode on the core's instruction bus, and reports the test selector and cycle count. Depths, widths, stop opcode, settle time and a run timeout are parameters.

Parameters:
- DATA_W, 32, width of stream words, external write data and instruction.
- ADDR_W, 32, width of external byte addresses.
- IMEM_DEPTH, 512, instruction words loaded; must be ≥1.
- DMEM_DEPTH, 1024, data words loaded; must be ≥1.
- SETTLE_CYCLES, 1, idle cycles between the last imem write and `enable` rising; must be ≥1.
- STOP_OPCODE, 6'b111110, value of instr_i[31:26] that ends the run.
- CYC_W, 32, cycle counter width.
- MAX_CYCLES, 2**20, run timeout in cycles; must be ≥1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- arst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle request to begin load+run.
- s_valid_i  in  1  image stream valid.
- s_data_i  in  DATA_W  image word; dmem words first, then imem words.
- s_ready_o  out  1  image stream ready.
- addr_ext_o  out  ADDR_W  imem external byte address.
- wen_ext_o  out  1  imem external write enable.
- ren_ext_o  out  1  imem external read enable; tied 0.
- wdata_ext_o  out  DATA_W  imem external write data.
- addr_ext_2_o  out  ADDR_W  dmem external byte address.
- wen_ext_2_o  out  1  dmem external write enable.
- ren_ext_2_o  out  1  dmem external read enable; tied 0.
- wdata_ext_2_o  out  DATA_W  dmem external write data.
- enable_o  out  1  core enable.
- instr_i  in  DATA_W  core's current instruction.
- busy_o  out  1  high in any state except IDLE, DONE, TIMEOUT.
- done_o  out  1  high in DONE.
- timeout_o  out  1  high in TIMEOUT.
- test_id_o  out  2  instr_i[1:0] captured at STOP.
- cycles_o  out  CYC_W  run cycle count.

Behaviour:
- Reset (async assert, sync release): state = IDLE. All outputs 0: addresses, data, enables, s_ready_o, status, test_id_o, cycles_o. Word index = 0.
- FSM states: IDLE, LOAD_D, LOAD_I, SETTLE, RUN, DONE, TIMEOUT.
- IDLE / DONE / TIMEOUT:
  - start_i=1 → LOAD_D next cycle.
  - Clears done_o, timeout_o, cycles_o, test_id_o and the index.
  - start_i is ignored in every other state.
- LOAD_D:
  - s_ready_o=1.
  - On each handshake (s_valid_i & s_ready_o), in the next cycle: wen_ext_2_o=1 for exactly one cycle, addr_ext_2_o = idx<<2, wdata_ext_2_o = s_data_i; idx increments.
  - No handshake → wen_ext_2_o=0; address and data hold their last value.
  - Handshake at idx = DMEM_DEPTH-1 → LOAD_I with idx = 0. No gap cycle is required between streams.
- LOAD_I: same rules on the imem port (wen_ext_o, addr_ext_o, wdata_ext_o).
  - Handshake at idx = IMEM_DEPTH-1 → SETTLE.
  - The final wen_ext_o pulse occurs in the first SETTLE cycle.
- Address width: idx<<2 is zero-extended or truncated to ADDR_W.
- SETTLE:
  - s_ready_o=0, enable_o=0.
  - Stays SETTLE_CYCLES cycles, then → RUN. enable_o is registered high in the first RUN cycle.
- RUN:
  - enable_o=1.
  - If instr_i[31:26]==STOP_OPCODE: → DONE; capture test_id_o = instr_i[1:0]; cycles_o is not incremented that cycle.
  - Otherwise cycles_o increments by 1.
  - If no STOP and cycles_o == MAX_CYCLES-1: → TIMEOUT.
  - STOP and the timeout condition in the same cycle → DONE (STOP wins).
  - cycles_o saturates at all-ones; it never wraps.
- DONE / TIMEOUT: enable_o=0 (registered, so it falls the cycle after detection); cycles_o and test_id_o hold.
- instr_i is ignored outside RUN.
- Stream words presented while s_ready_o=0 are not consumed.
- arst_n low mid-load or mid-run aborts immediately; all outputs return to reset values asynchronously.

Test Plan:
1. DMEM_DEPTH=4, IMEM_DEPTH=4, continuous valid, words 0x10..0x17 → wen_ext_2_o pulses carry addr 0,4,8,C with data 0x10..0x13; wen_ext_o pulses carry addr 0,4,8,C with data 0x14..0x17; enable_o rises SETTLE_CYCLES+1 cycles after the last handshake.
2. Valid toggled 1,0,1,0 during load → s_ready_o stays 1; exactly one write pulse per accepted word; addresses have no gaps; stalled cycles give wen=0.
3. instr_i = 0xF8000002 driven on the 5th RUN cycle → done_o=1, test_id_o=2, cycles_o=4, enable_o=0 the next cycle.
4. MAX_CYCLES=8, no STOP → timeout_o=1 with cycles_o=7; STOP driven in the same cycle instead → done_o=1, timeout_o=0.
5. arst_n pulsed low during LOAD_I idx=2 → all outputs 0 immediately; after release, start_i reloads from dmem idx 0.
6. start_i during RUN → ignored. start_i in DONE → status cleared, LOAD_D entered next cycle.
